regs_cmd_initiator: RTL

REGS_CMD_INITIATOR -- requirements
Module: regs_cmd_initiator

---
 rtl/regs_cmd_initiator.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/regs_cmd_initiator.sv
// Register command initiator: queues read/write requests in a small FIFO and
// issues them one at a time on a simple register command port.
module regs_cmd_initiator #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wr_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [1:0]        cmd_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [DATA_W-1:0] cmd_data_w_o,
  input  logic [DATA_W-1:0] cmd_data_r_i,
  output logic              busy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [2:0] LAT_INIT  = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RD, ST_RESP} state_t;

  logic              fifo_wr_mem   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop, fifo_empty, fifo_full;
  logic             head_wr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  state_t            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic              load_next;

  assign fifo_full   = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign req_ready_o = !fifo_full;
  assign push        = req_valid_i && !fifo_full;

  assign head_wr   = fifo_wr_mem[rd_ptr_q];
  assign head_addr = fifo_addr_mem[rd_ptr_q];
  assign head_data = fifo_data_mem[rd_ptr_q];

  // Storage needs no reset: occupancy is tracked solely by the pointers/count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_wr_mem[wr_ptr_q]   <= req_wr_i;
      fifo_addr_mem[wr_ptr_q] <= req_addr_i;
      fifo_data_mem[wr_ptr_q] <= req_wdata_i;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = CMD_IDLE;
    cmd_addr_d  = '0;
    cmd_data_d  = '0;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    lat_cnt_d   = lat_cnt_q;
    load_next   = 1'b0;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: load_next = !fifo_empty;
      ST_ISSUE: begin
        if (cmd_q == CMD_READ) begin
          state_d    = ST_WAIT_RD;
          lat_cnt_d  = LAT_INIT;
          rsp_addr_d = cmd_addr_q;
        end else if (!fifo_empty) begin
          load_next = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RD: begin
        if (lat_cnt_q == 3'd0) begin
          rsp_rdata_d = cmd_data_r_i;
          state_d     = ST_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          if (!fifo_empty) load_next = 1'b1;
          else             state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Popping the head always lands in ISSUE with a one-cycle command.
    if (load_next) begin
      pop        = 1'b1;
      state_d    = ST_ISSUE;
      cmd_d      = head_wr ? CMD_WRITE : CMD_READ;
      cmd_addr_d = head_addr;
      cmd_data_d = head_wr ? head_data : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_IDLE;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      lat_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

  assign cmd_o        = cmd_q;
  assign cmd_addr_o   = cmd_addr_q;
  assign cmd_data_w_o = cmd_data_q;
  assign rsp_valid_o  = (state_q == ST_RESP);
  assign rsp_addr_o   = rsp_addr_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign busy_o       = !fifo_empty || (state_q != ST_IDLE);

endmodule
